arbiter_rr_sdp: RTL and testbench
=================================

Name: arbiter_rr_sdp

Overview:
- Shares one single-port dynamic-latency memory between NUM_PORTS requesters using round-robin arbitration.
- Each requester uses the Calyx go/done style:
  - it holds read_en or write_en high until it sees its one-cycle done pulse;
  - it then drops the enable on the following cycle.
- Sits between N memory-access groups and one memory with a go/done interface.
- Adds a per-transaction watchdog so a stalled memory cannot hang a requester.

Parameters:
- WIDTH, 32, data width.
- SIZE, 16, memory depth in words.
- IDX_SIZE, 4, address width.
- NUM_PORTS, 4, number of requesters (2..16).
- TIMEOUT, 0, maximum cycles in BUSY before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- addr  in  NUM_PORTS*IDX_SIZE  per-port address, port k at [k*IDX_SIZE +: IDX_SIZE].
- in  in  NUM_PORTS*WIDTH  per-port write data.
- read_en  in  NUM_PORTS  per-port read request.
- write_en  in  NUM_PORTS  per-port write request.
- out  out  NUM_PORTS*WIDTH  per-port registered read data.
- read_done  out  NUM_PORTS  one-cycle read completion pulse.
- write_done  out  NUM_PORTS  one-cycle write completion pulse.
- mem_addr  out  IDX_SIZE  memory address.
- mem_in  out  WIDTH  memory write data.
- mem_read_en  out  1  memory read go.
- mem_write_en  out  1  memory write go.
- mem_out  in  WIDTH  memory read data.
- mem_read_done  in  1  memory read done.
- mem_write_done  in  1  memory write done.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (reset_n=0 at a clk edge), including mid-transaction:
  - state=IDLE, every out word=0, all done bits=0, timeout_err=0.
  - rr_ptr=NUM_PORTS-1, so port 0 wins the first tie.
  - Watchdog counter=0.
  - Any in-flight memory access is abandoned.
- Request: port k requests when read_en[k] | write_en[k]. If both are high, the write is performed and the read is ignored for that transaction.
- FSM has three states: IDLE, BUSY, RESP.
- IDLE:
  - If any port requests, pick the first requesting port scanning from rr_ptr+1 modulo NUM_PORTS.
  - Latch that port's index g, operation (write or read), addr[g] and in[g]. Set rr_ptr=g. Go to BUSY.
  - If no port requests, stay in IDLE.
- BUSY:
  - mem_addr = latched address.
  - mem_read_en = 1 if the latched op is read.
  - mem_write_en = 1 if the latched op is write.
  - mem_in = latched data when the op is write, else 0.
  - All mem_* outputs are 0 in IDLE and RESP.
  - Only the done matching the latched op is honoured; mem_read_done during a write is ignored, and vice versa.
  - On matching done: assert read_done[g] or write_done[g] on the next edge. For a read, out[g] <= mem_out at that edge. Go to RESP.
- RESP: the done bit is high for exactly this one cycle and is cleared on exit. Always go to IDLE. No grant is made in RESP, because the requester's enable is still high this cycle.
- Latency:
  - Request sampled in IDLE at edge t, so mem_*_en is high during cycle t+1.
  - Memory done sampled at edge m, so the port's done is high during cycle m+1.
  - Minimum turnaround is 3 cycles per transaction.
- Watchdog (TIMEOUT>0):
  - Counter clears on entering BUSY and increments every BUSY cycle.
  - If the counter reaches TIMEOUT-1 with no matching done, at that edge: set timeout_err=1 (sticky until reset), pulse the port's done as usual, leave out[g] unchanged, go to RESP.
  - If a matching done arrives on that same cycle, normal completion wins and timeout_err is not set.
- Fairness: after serving port g, port g has the lowest priority, so N continuously requesting ports are each served once per N transactions.
- out[k] holds its value until the next read completion on port k. Other ports' out words never change.
- Enables that drop while the port is waiting are not legal stimulus; the latched transaction still completes.

Decomposition:
- Package arb_pkg holds:
  - typedef enum arb_state_e {IDLE, BUSY, RESP};
  - typedef enum arb_op_e {OP_READ, OP_WRITE};
  - localparam for the watchdog counter width, computed as $clog2(TIMEOUT+1), minimum 1.
- One sub-module, rr_pick: combinational rotating-priority encoder.
  - Inputs: req[NUM_PORTS-1:0], base.
  - Outputs: valid, idx.
  - Unit-testable on its own.

Test Plan:
- Single port 2 write addr 5 data 0xDEAD, memory done 2 cycles after go -> mem_write_en high 2 cycles with mem_addr=5, mem_in=0xDEAD; write_done[2] high exactly 1 cycle; no other done bits.
- All 4 ports reading continuously, memory done after 1 cycle -> grant order 0,1,2,3,0,...; each out[k] equals mem_out captured at its done; read_done never in back-to-back cycles.
- Port 1 read_en and write_en both high -> only mem_write_en asserted; write_done[1] pulses; read_done[1] stays 0; out[1] unchanged.
- TIMEOUT=8, memory never responds to port 3 read -> done pulse on port 3 eight cycles after grant; timeout_err=1 and stays 1; out[3] unchanged; next request is served normally.
- reset_n=0 asserted mid-BUSY -> next cycle all mem_*_en=0, all outputs 0, state IDLE; first grant after release goes to the lowest-index requester.
- During a read, mem_write_done pulses before mem_read_done -> stray write done ignored; completion only on mem_read_done.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and sizing helpers for the round-robin single-port memory arbiter.
package arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_e;
    typedef enum logic {OP_READ, OP_WRITE} arb_op_e;

    localparam int WD_W_MIN = 1;

    // Watchdog counter width: $clog2(TIMEOUT+1), never narrower than one bit.
    function automatic int wd_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < WD_W_MIN) ? WD_W_MIN : w;
    endfunction

endpackage

// File: rtl/arbiter_rr_sdp_if.sv
// Bundle of the requester-side and memory-side signals of arbiter_rr_sdp.
interface arbiter_rr_sdp_if #(
    parameter int WIDTH     = 32,
    parameter int IDX_SIZE  = 4,
    parameter int NUM_PORTS = 4
);
    logic [NUM_PORTS*IDX_SIZE-1:0] addr;
    logic [NUM_PORTS*WIDTH-1:0]    in;
    logic [NUM_PORTS-1:0]          read_en;
    logic [NUM_PORTS-1:0]          write_en;
    logic [NUM_PORTS*WIDTH-1:0]    out;
    logic [NUM_PORTS-1:0]          read_done;
    logic [NUM_PORTS-1:0]          write_done;
    logic [IDX_SIZE-1:0]           mem_addr;
    logic [WIDTH-1:0]              mem_in;
    logic                          mem_read_en;
    logic                          mem_write_en;
    logic [WIDTH-1:0]              mem_out;
    logic                          mem_read_done;
    logic                          mem_write_done;
    logic                          timeout_err;

    // Arbiter view.
    modport slave (
        input  addr, in, read_en, write_en, mem_out, mem_read_done, mem_write_done,
        output out, read_done, write_done, mem_addr, mem_in, mem_read_en, mem_write_en,
               timeout_err
    );

    // Environment view: requesters plus the memory.
    modport master (
        output addr, in, read_en, write_en, mem_out, mem_read_done, mem_write_done,
        input  out, read_done, write_done, mem_addr, mem_in, mem_read_en, mem_write_en,
               timeout_err
    );
endinterface

// File: rtl/arbiter_rr_sdp_rr_pick.sv
// Rotating-priority encoder: first set bit of req scanning upward from base+1, wrapping.
module rr_pick #(
    parameter int NUM_PORTS = 4,
    parameter int PW        = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PW-1:0]        base,
    output logic                 valid,
    output logic [PW-1:0]        idx
);
    logic [PW-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = PW'((int'(base) + i) % NUM_PORTS);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end
endmodule

// File: rtl/arbiter_rr_sdp.sv
// Round-robin arbiter sharing one go/done memory among NUM_PORTS go/done requesters.
module arbiter_rr_sdp
    import arb_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int SIZE      = 16,
    parameter int IDX_SIZE  = 4,
    parameter int NUM_PORTS = 4,
    parameter int TIMEOUT   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    arbiter_rr_sdp_if.slave  bus
);
    localparam int              PW      = $clog2(NUM_PORTS);
    localparam int              WD_W    = wd_width(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
    localparam logic [PW-1:0]   PTR_RST = PW'(NUM_PORTS - 1);

    if (NUM_PORTS < 2 || NUM_PORTS > 16 || SIZE > (1 << IDX_SIZE)) begin : g_param_check
        $error("arbiter_rr_sdp: unsupported NUM_PORTS/SIZE/IDX_SIZE combination");
    end

    arb_state_e           state_q, state_d;
    arb_op_e              op_q, op_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]        g_q, g_d;
    logic [IDX_SIZE-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic [WIDTH-1:0]     out_q [NUM_PORTS];
    logic [WIDTH-1:0]     out_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] rdone_q, rdone_d;
    logic [NUM_PORTS-1:0] wdone_q, wdone_d;
    logic                 err_q, err_d;

    logic [NUM_PORTS-1:0] req;
    logic [IDX_SIZE-1:0]  addr_a [NUM_PORTS];
    logic [WIDTH-1:0]     in_a   [NUM_PORTS];
    logic                 pick_valid;
    logic [PW-1:0]        pick_idx;
    logic                 mem_done;
    logic                 wd_expire;

    assign req = bus.read_en | bus.write_en;

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
        assign addr_a[k]                   = bus.addr[k*IDX_SIZE +: IDX_SIZE];
        assign in_a[k]                     = bus.in[k*WIDTH +: WIDTH];
        assign bus.out[k*WIDTH +: WIDTH]   = out_q[k];
    end

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PW        (PW)
    ) u_pick (
        .req   (req),
        .base  (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // A done for the other operation type is deliberately ignored.
    assign mem_done  = (op_q == OP_WRITE) ? bus.mem_write_done : bus.mem_read_done;
    assign wd_expire = (TIMEOUT > 0) && (wd_q == WD_LAST);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rr_ptr_d = rr_ptr_q;
        g_d      = g_q;
        addr_d   = addr_q;
        data_d   = data_q;
        wd_d     = wd_q;
        out_d    = out_q;
        rdone_d  = '0;
        wdone_d  = '0;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    g_d      = pick_idx;
                    rr_ptr_d = pick_idx;
                    op_d     = bus.write_en[pick_idx] ? OP_WRITE : OP_READ;
                    addr_d   = addr_a[pick_idx];
                    data_d   = in_a[pick_idx];
                    wd_d     = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                // A real completion on the expiry cycle takes precedence over the abort.
                if (mem_done || wd_expire) begin
                    state_d = RESP;
                    if (op_q == OP_WRITE) wdone_d[g_q] = 1'b1;
                    else                  rdone_d[g_q] = 1'b1;
                    if (mem_done) begin
                        if (op_q == OP_READ) out_d[g_q] = bus.mem_out;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_addr     = '0;
        bus.mem_in       = '0;
        bus.mem_read_en  = 1'b0;
        bus.mem_write_en = 1'b0;
        if (state_q == BUSY) begin
            bus.mem_addr = addr_q;
            if (op_q == OP_WRITE) begin
                bus.mem_write_en = 1'b1;
                bus.mem_in       = data_q;
            end else begin
                bus.mem_read_en = 1'b1;
            end
        end
    end

    assign bus.read_done   = rdone_q;
    assign bus.write_done  = wdone_q;
    assign bus.timeout_err = err_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= PTR_RST;
            wd_q     <= '0;
            out_q    <= '{default: '0};
            rdone_q  <= '0;
            wdone_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            wd_q     <= wd_d;
            out_q    <= out_d;
            rdone_q  <= rdone_d;
            wdone_q  <= wdone_d;
            err_q    <= err_d;
        end
    end

    // Latched transaction fields are only consumed in BUSY, so they need no reset.
    always_ff @(posedge clk) begin
        op_q   <= op_d;
        g_q    <= g_d;
        addr_q <= addr_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_arbiter_rr_sdp.sv
// Scoreboard bench for arbiter_rr_sdp: directed requester/memory scenarios, decoupled done monitor.
module tb_arbiter_rr_sdp;
    localparam int W  = 32;
    localparam int IW = 4;
    localparam int N  = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    arbiter_rr_sdp_if #(.WIDTH(W), .IDX_SIZE(IW), .NUM_PORTS(N)) bus ();

    arbiter_rr_sdp #(
        .WIDTH(W), .SIZE(16), .IDX_SIZE(IW), .NUM_PORTS(N), .TIMEOUT(TO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int           port;
        bit           wr;
        logic [W-1:0] out_exp;
        bit           err;
    } exp_t;
    exp_t sbq[$];

    int mem_lat   = 1;
    bit mem_mute  = 1'b0;
    bit mem_stray = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int p, input bit wr, input logic [W-1:0] o, input bit e);
        exp_t x;
        x.port = p; x.wr = wr; x.out_exp = o; x.err = e;
        sbq.push_back(x);
    endtask

    // Memory model: done during the mem_lat-th cycle of go, optional mute and stray pulse.
    initial begin
        logic [W-1:0] mem_arr [16];
        int en_cnt;
        en_cnt = 0;
        for (int a = 0; a < 16; a++) mem_arr[a] = 32'h1000_0000 + a;
        bus.mem_read_done  = 1'b0;
        bus.mem_write_done = 1'b0;
        bus.mem_out        = 32'hBAD0_BAD0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_read_done  = 1'b0;
            bus.mem_write_done = 1'b0;
            bus.mem_out        = 32'hBAD0_BAD0;
            if (bus.mem_read_en || bus.mem_write_en) begin
                en_cnt++;
                if (!mem_mute && en_cnt == mem_lat) begin
                    if (bus.mem_write_en) begin
                        mem_arr[bus.mem_addr] = bus.mem_in;
                        bus.mem_write_done = 1'b1;
                    end else begin
                        bus.mem_out       = mem_arr[bus.mem_addr];
                        bus.mem_read_done = 1'b1;
                    end
                end else if (mem_stray && en_cnt == 1 && bus.mem_read_en) begin
                    bus.mem_write_done = 1'b1;
                end
            end else begin
                en_cnt = 0;
            end
        end
    end

    // Monitor: every done pulse pops one expected completion.
    initial begin
        exp_t           e;
        logic [2*N-1:0] dv;
        logic [2*N-1:0] ev;
        bit             prev_dn;
        prev_dn = 1'b0;
        forever begin
            @(negedge clk);
            dv = {bus.write_done, bus.read_done};
            if (dv != '0) begin
                chk("done_not_back_to_back", prev_dn, 0);
                if (sbq.size() == 0) begin
                    chk("unexpected_done", dv, 0);
                end else begin
                    e  = sbq.pop_front();
                    ev = '0;
                    ev[e.wr ? N + e.port : e.port] = 1'b1;
                    chk("done_vector", dv, ev);
                    chk("out_word", bus.out[e.port*W +: W], e.out_exp);
                    chk("timeout_err_at_done", bus.timeout_err, e.err);
                end
            end
            prev_dn = (dv != '0);
        end
    end

    task automatic do_txn(input int p, input bit rd, input bit wr, input logic [IW-1:0] a,
                          input logic [W-1:0] d, output int n_rd, output int n_wr);
        bit got;
        got  = 1'b0;
        n_rd = 0;
        n_wr = 0;
        @(posedge clk);
        #1;
        bus.addr[p*IW +: IW] = a;
        bus.in[p*W +: W]     = d;
        bus.read_en[p]       = rd;
        bus.write_en[p]      = wr;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (bus.mem_read_en) begin
                n_rd++;
                chk("mem_addr_rd", bus.mem_addr, a);
                chk("mem_in_rd_zero", bus.mem_in, 0);
            end
            if (bus.mem_write_en) begin
                n_wr++;
                chk("mem_addr_wr", bus.mem_addr, a);
                chk("mem_in_wr", bus.mem_in, d);
            end
            if (bus.read_done[p] || bus.write_done[p]) got = 1'b1;
        end
        chk("txn_done_seen", got, 1);
        @(posedge clk);
        #1;
        bus.read_en[p]  = 1'b0;
        bus.write_en[p] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        int nr, nw, total;
        bit got;
        bit drop [N];
        bit raise [N];
        int served [N];

        reset_n      = 1'b0;
        bus.addr     = '0;
        bus.in       = '0;
        bus.read_en  = '0;
        bus.write_en = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_read_done", bus.read_done, 0);
        chk("rst_write_done", bus.write_done, 0);
        chk("rst_out_lo", bus.out[63:0], 0);
        chk("rst_out_hi", bus.out[127:64], 0);
        chk("rst_mem_read_en", bus.mem_read_en, 0);
        chk("rst_mem_write_en", bus.mem_write_en, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_timeout_err", bus.timeout_err, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // All four ports reading continuously: order 0,1,2,3,0,1,2,3.
        for (int k = 0; k < N; k++) push(k, 1'b0, 32'h1000_0008 + k, 1'b0);
        for (int k = 0; k < N; k++) push(k, 1'b0, 32'h1000_000C + k, 1'b0);
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            bus.addr[k*IW +: IW] = IW'(8 + k);
            bus.read_en[k] = 1'b1;
            drop[k] = 1'b0; raise[k] = 1'b0; served[k] = 0;
        end
        total = 0;
        for (int c = 0; c < 100 && total < 8; c++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) if (bus.read_done[k]) drop[k] = 1'b1;
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (raise[k]) begin
                    bus.read_en[k] = 1'b1;
                    raise[k] = 1'b0;
                end
                if (drop[k]) begin
                    bus.read_en[k] = 1'b0;
                    drop[k] = 1'b0;
                    served[k]++;
                    total++;
                    if (served[k] < 2) begin
                        raise[k] = 1'b1;
                        bus.addr[k*IW +: IW] = IW'(12 + k);
                    end
                end
            end
        end
        chk("rr_all_served", total, 8);

        // Port 2 write, memory done on the 2nd go cycle; read it back on port 0.
        mem_lat = 2;
        push(2, 1'b1, 32'h1000_000E, 1'b0);
        do_txn(2, 1'b0, 1'b1, 4'd5, 32'h0000_DEAD, nr, nw);
        chk("t1_wr_cycles", nw, 2);
        chk("t1_rd_cycles", nr, 0);
        mem_lat = 1;
        push(0, 1'b0, 32'h0000_DEAD, 1'b0);
        do_txn(0, 1'b1, 1'b0, 4'd5, 32'h0, nr, nw);
        chk("t1_readback_rd_cycles", nr, 1);

        // Port 1 with read_en and write_en both high: write wins.
        push(1, 1'b1, 32'h1000_000D, 1'b0);
        do_txn(1, 1'b1, 1'b1, 4'd6, 32'h1234_5678, nr, nw);
        chk("t3_wr_cycles", nw, 1);
        chk("t3_rd_cycles", nr, 0);
        push(2, 1'b0, 32'h1234_5678, 1'b0);
        do_txn(2, 1'b1, 1'b0, 4'd6, 32'h0, nr, nw);
        chk("t3_readback_rd_cycles", nr, 1);

        // Stray mem_write_done during a read must be ignored.
        mem_lat   = 3;
        mem_stray = 1'b1;
        push(0, 1'b0, 32'h1000_0007, 1'b0);
        do_txn(0, 1'b1, 1'b0, 4'd7, 32'h0, nr, nw);
        chk("t6_rd_cycles", nr, 3);
        mem_stray = 1'b0;
        mem_lat   = 1;

        // Silent memory on port 3 read: watchdog aborts after 8 BUSY cycles.
        mem_mute = 1'b1;
        push(3, 1'b0, 32'h1000_000F, 1'b1);
        do_txn(3, 1'b1, 1'b0, 4'd9, 32'h0, nr, nw);
        chk("t4_busy_cycles", nr, 8);
        mem_mute = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_err_sticky", bus.timeout_err, 1);
        push(3, 1'b0, 32'h1000_000A, 1'b1);
        do_txn(3, 1'b1, 1'b0, 4'd10, 32'h0, nr, nw);
        chk("t4_next_rd_cycles", nr, 1);

        // Reset in the middle of BUSY.
        mem_mute = 1'b1;
        @(posedge clk);
        #1;
        bus.addr[2*IW +: IW] = 4'd3;
        bus.read_en[2] = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (bus.mem_read_en) got = 1'b1;
        end
        chk("t5_busy_reached", got, 1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        bus.read_en[2] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t5_mem_read_en", bus.mem_read_en, 0);
        chk("t5_mem_write_en", bus.mem_write_en, 0);
        chk("t5_mem_addr", bus.mem_addr, 0);
        chk("t5_mem_in", bus.mem_in, 0);
        chk("t5_out_lo", bus.out[63:0], 0);
        chk("t5_out_hi", bus.out[127:64], 0);
        chk("t5_read_done", bus.read_done, 0);
        chk("t5_write_done", bus.write_done, 0);
        chk("t5_timeout_err", bus.timeout_err, 0);
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        mem_mute = 1'b0;
        mem_lat  = 1;
        push(1, 1'b0, 32'h1000_0001, 1'b0);
        push(3, 1'b1, 32'h0, 1'b0);
        bus.addr[1*IW +: IW] = 4'd1;
        bus.addr[3*IW +: IW] = 4'd2;
        bus.in[3*W +: W]     = 32'h0000_0055;
        bus.read_en[1]  = 1'b1;
        bus.write_en[3] = 1'b1;
        drop[1] = 1'b0;
        drop[3] = 1'b0;
        total   = 0;
        for (int c = 0; c < 40 && total < 2; c++) begin
            @(negedge clk);
            if (bus.read_done[1])  drop[1] = 1'b1;
            if (bus.write_done[3]) drop[3] = 1'b1;
            @(posedge clk);
            #1;
            if (drop[1]) begin bus.read_en[1] = 1'b0;  drop[1] = 1'b0; total++; end
            if (drop[3]) begin bus.write_en[3] = 1'b0; drop[3] = 1'b0; total++; end
        end
        chk("t5_both_served", total, 2);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
